// File: rtl/burst_checker.sv
// burst_checker: AXI4 write-slave sink that checks incrementing bursts from
// the burst data generator and keeps saturating status counters.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   S_AXI_AW*          write address channel (one outstanding burst)
//   S_AXI_W*           write data channel (replicated 16-bit counter pattern)
//   S_AXI_B*           write response (SLVERR if anything in the burst failed)
//   clear              pulse: zero counters, reload expected address/word
//   burst_count        completed B handshakes
//   beat_count         accepted W beats
//   data_errors        beats with bad WDATA or WSTRB
//   addr_errors        bursts with unexpected AWADDR
//   proto_errors       bad AWSIZE/AWBURST or misplaced WLAST
//   first_error_beat   beat_count of the first data-error beat
//   error              any error counter nonzero
module burst_checker #(
  parameter int unsigned           DATA_WIDTH = 512,
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h1_0000_0000,
  parameter logic [15:0]           FIRST_WORD = 16'h0001
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic [3:0]              S_AXI_AWID,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic [3:0]              S_AXI_BID,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic                    clear,
  output logic [31:0]             burst_count,
  output logic [31:0]             beat_count,
  output logic [31:0]             data_errors,
  output logic [31:0]             addr_errors,
  output logic [31:0]             proto_errors,
  output logic [31:0]             first_error_beat,
  output logic                    error
);

  localparam int unsigned NWORDS      = DATA_WIDTH / 16;
  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [3:0]              bid_q, bid_d;
  logic [7:0]              beats_left_q, beats_left_d;
  logic                    burst_bad_q, burst_bad_d;
  logic [15:0]             exp_word_q, exp_word_d;
  logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;
  logic [31:0]             burst_cnt_q, burst_cnt_d;
  logic [31:0]             beat_cnt_q, beat_cnt_d;
  logic [31:0]             data_err_q, data_err_d;
  logic [31:0]             addr_err_q, addr_err_d;
  logic [31:0]             proto_err_q, proto_err_d;
  logic [31:0]             first_err_q, first_err_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   pattern;
  logic                    beat_bad;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    pattern  = {NWORDS{exp_word_q}};
    beat_bad = (S_AXI_WDATA != pattern) || (S_AXI_WSTRB != '1);

    state_d      = state_q;
    bresp_d      = bresp_q;
    bid_d        = bid_q;
    beats_left_d = beats_left_q;
    burst_bad_d  = burst_bad_q;
    exp_word_d   = exp_word_q;
    exp_addr_d   = exp_addr_q;
    burst_cnt_d  = burst_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    data_err_d   = data_err_q;
    addr_err_d   = addr_err_q;
    proto_err_d  = proto_err_q;
    first_err_d  = first_err_q;

    case (state_q)
      S_INIT: state_d = S_IDLE;

      S_IDLE: begin
        if (S_AXI_AWVALID) begin
          beats_left_d = S_AXI_AWLEN;
          bid_d        = S_AXI_AWID;
          burst_bad_d  = 1'b0;
          state_d      = S_DATA;
          if (S_AXI_AWADDR != exp_addr_q) begin
            addr_err_d  = sat_inc(addr_err_q);
            burst_bad_d = 1'b1;
          end
          if (S_AXI_AWSIZE != 3'd6 || S_AXI_AWBURST != 2'd1) begin
            proto_err_d = sat_inc(proto_err_q);
            burst_bad_d = 1'b1;
          end
          // Advance from the expected address so a bad AWADDR never resyncs.
          exp_addr_d = exp_addr_q + ((ADDR_WIDTH'(S_AXI_AWLEN) + ADDR_WIDTH'(1)) << 6);
        end
      end

      S_DATA: begin
        if (S_AXI_WVALID) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          exp_word_d = exp_word_q + 16'd1;
          if (beat_bad) begin
            data_err_d  = sat_inc(data_err_q);
            burst_bad_d = 1'b1;
            if (data_err_q == '0) first_err_d = beat_cnt_q;
          end
          if (S_AXI_WLAST != (beats_left_q == '0)) begin
            proto_err_d = sat_inc(proto_err_q);
            burst_bad_d = 1'b1;
          end
          // The burst ends on the AWLEN count, not on WLAST.
          if (beats_left_q != '0) begin
            beats_left_d = beats_left_q - 8'd1;
          end else begin
            bresp_d = burst_bad_d ? RESP_SLVERR : RESP_OKAY;
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (S_AXI_BREADY) begin
          burst_cnt_d = sat_inc(burst_cnt_q);
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_INIT;
    endcase

    // clear overrides any same-cycle increment but leaves the burst running.
    if (clear) begin
      burst_cnt_d = '0;
      beat_cnt_d  = '0;
      data_err_d  = '0;
      addr_err_d  = '0;
      proto_err_d = '0;
      first_err_d = '0;
      exp_word_d  = FIRST_WORD;
      exp_addr_d  = BASE_ADDR;
    end

    error_d   = (data_err_d != '0) || (addr_err_d != '0) || (proto_err_d != '0);
    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      bid_q        <= '0;
      beats_left_q <= '0;
      burst_bad_q  <= 1'b0;
      exp_word_q   <= FIRST_WORD;
      exp_addr_q   <= BASE_ADDR;
      burst_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      data_err_q   <= '0;
      addr_err_q   <= '0;
      proto_err_q  <= '0;
      first_err_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      bid_q        <= bid_d;
      beats_left_q <= beats_left_d;
      burst_bad_q  <= burst_bad_d;
      exp_word_q   <= exp_word_d;
      exp_addr_q   <= exp_addr_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      data_err_q   <= data_err_d;
      addr_err_q   <= addr_err_d;
      proto_err_q  <= proto_err_d;
      first_err_q  <= first_err_d;
      error_q      <= error_d;
    end
  end

  assign S_AXI_AWREADY    = awready_q;
  assign S_AXI_WREADY     = wready_q;
  assign S_AXI_BVALID     = bvalid_q;
  assign S_AXI_BRESP      = bresp_q;
  assign S_AXI_BID        = bid_q;
  assign burst_count      = burst_cnt_q;
  assign beat_count       = beat_cnt_q;
  assign data_errors      = data_err_q;
  assign addr_errors      = addr_err_q;
  assign proto_errors     = proto_err_q;
  assign first_error_beat = first_err_q;
  assign error            = error_q;

endmodule

// File: tb/tb_burst_checker.sv
// tb_burst_checker: directed and randomized bursts into burst_checker,
// compared against a transaction-level model of the expected counters and
// responses. FIRST_WORD is set near 16'hFFFF so the pattern wrap is reached
// within a short stream.
module tb_burst_checker;

  localparam int unsigned DW   = 512;
  localparam int unsigned SW   = DW / 8;
  localparam logic [63:0] BASE = 64'h1_0000_0000;
  localparam logic [15:0] FW   = 16'hFFC0;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [63:0]   awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = 3'd6;
  logic [1:0]    awburst = 2'd1;
  logic [3:0]    awid = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic [3:0]    bid;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   burst_count, beat_count, data_errors, addr_errors, proto_errors;
  logic [31:0]   first_error_beat;
  logic          error;

  burst_checker #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(64),
    .BASE_ADDR (BASE),
    .FIRST_WORD(FW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWID(awid), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .clear(clear),
    .burst_count(burst_count), .beat_count(beat_count),
    .data_errors(data_errors), .addr_errors(addr_errors),
    .proto_errors(proto_errors), .first_error_beat(first_error_beat),
    .error(error)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Transaction-level reference state.
  logic [15:0] m_word;
  logic [63:0] m_addr;
  int unsigned m_bursts, m_beats, m_derr, m_aerr, m_perr, m_first;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sinc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_word = FW; m_addr = BASE;
    m_bursts = 0; m_beats = 0; m_derr = 0; m_aerr = 0; m_perr = 0; m_first = 0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".bursts"}, 64'(burst_count), 64'(m_bursts));
    check({tag, ".beats"}, 64'(beat_count), 64'(m_beats));
    check({tag, ".derr"}, 64'(data_errors), 64'(m_derr));
    check({tag, ".aerr"}, 64'(addr_errors), 64'(m_aerr));
    check({tag, ".perr"}, 64'(proto_errors), 64'(m_perr));
    check({tag, ".first"}, 64'(first_error_beat), 64'(m_first));
    check({tag, ".error"}, 64'(error), 64'((m_derr + m_aerr + m_perr) != 0));
  endtask

  task automatic do_reset();
    resetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; clear = 1'b0;
    step(); step();
    resetn = 1'b1;
    model_clear();
    check("rst.awready", 64'(awready), 64'd0);
    check("rst.bvalid", 64'(bvalid), 64'd0);
    check("rst.bresp", 64'(bresp), 64'd0);
    check("rst.bid", 64'(bid), 64'd0);
    check_counters("rst");
    step();
    check("init.awready", 64'(awready), 64'd1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    check_counters("clear");
  endtask

  // One full AW/W/B transaction. Negative beat indices disable an injection.
  task automatic burst(input logic [63:0] addr, input int unsigned len,
                       input logic [2:0] size, input logic [1:0] btype,
                       input logic [3:0] id, input int flip_beat,
                       input int strb_beat, input int wl_early, input bit wl_drop,
                       input int unsigned bdelay, input bit gaps, input bit hold_aw,
                       input int clr_beat);
    int unsigned n;
    bit          bad;
    bit          dbad;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          wl;
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = btype; awid = id;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin step(); n++; end
    if (n >= 200) begin
      check("aw.timeout", 64'd0, 64'd1);
      awvalid = 1'b0;
      return;
    end
    step();
    awvalid = 1'b0;
    bad = 1'b0;
    if (addr != m_addr) begin m_aerr = sinc(m_aerr); bad = 1'b1; end
    if (size != 3'd6 || btype != 2'd1) begin m_perr = sinc(m_perr); bad = 1'b1; end
    m_addr = m_addr + 64'((len + 1) * 64);
    check("wready.lat", 64'(wready), 64'd1);

    for (int k = 0; k <= int'(len); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      d = {DW/16{m_word}};
      if (k == flip_beat) d[100] = ~d[100];
      s = '1;
      if (k == strb_beat) s[$urandom_range(0, SW-1)] = 1'b0;
      wl = (k == int'(len));
      if (k == wl_early) wl = 1'b1;
      if (k == int'(len) && wl_drop) wl = 1'b0;
      wdata = d; wstrb = s; wlast = wl; wvalid = 1'b1;
      if (k == clr_beat) clear = 1'b1;
      n = 0;
      while (!wready && n < 200) begin step(); n++; end
      if (n >= 200) begin
        check("w.timeout", 64'd0, 64'd1);
        wvalid = 1'b0; clear = 1'b0;
        return;
      end
      step();
      wvalid = 1'b0; clear = 1'b0;
      dbad = (k == flip_beat) || (k == strb_beat);
      if (dbad) begin
        if (m_derr == 0) m_first = m_beats;
        m_derr = sinc(m_derr);
        bad = 1'b1;
      end
      if (wl != (k == int'(len))) begin m_perr = sinc(m_perr); bad = 1'b1; end
      m_beats = sinc(m_beats);
      m_word = m_word + 16'd1;
      if (k == clr_beat) model_clear();
    end

    check("bvalid.lat", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), bad ? 64'd2 : 64'd0);
    check("bid", 64'(bid), 64'(id));
    if (hold_aw) begin awaddr = m_addr; awlen = 8'd0; awvalid = 1'b1; end
    for (int unsigned i = 0; i < bdelay; i++) begin
      step();
      check("bwait.bvalid", 64'(bvalid), 64'd1);
      check("bwait.bresp", 64'(bresp), bad ? 64'd2 : 64'd0);
      check("bwait.bid", 64'(bid), 64'(id));
      check("bwait.awready", 64'(awready), 64'd0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    awvalid = 1'b0;
    m_bursts = sinc(m_bursts);
    check("b.awready_next", 64'(awready), 64'd1);
    check("b.bvalid_drop", 64'(bvalid), 64'd0);
    check_counters("burst");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Clean back-to-back bursts.
    do_reset();
    for (int i = 0; i < 4; i++)
      burst(BASE + 64'(i * 256), 3, 3'd6, 2'd1, 4'(i), -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("t1.bursts", 64'(burst_count), 64'd4);
    check("t1.beats", 64'(beat_count), 64'd16);
    check("t1.error", 64'(error), 64'd0);

    // Data corruption on global beat 6 (burst 1, beat 2).
    do_reset();
    for (int i = 0; i < 4; i++)
      burst(BASE + 64'(i * 256), 3, 3'd6, 2'd1, 4'(i), (i == 1) ? 2 : -1, -1, -1, 1'b0,
            0, 1'b0, 1'b0, -1);
    check("t2.derr", 64'(data_errors), 64'd1);
    check("t2.first", 64'(first_error_beat), 64'd6);
    check("t2.error", 64'(error), 64'd1);

    // WLAST early on beat 1 and missing on beat 3, then a bad AWSIZE.
    do_reset();
    burst(BASE, 3, 3'd6, 2'd1, 4'd5, -1, -1, 1, 1'b1, 0, 1'b0, 1'b0, -1);
    check("t3.perr", 64'(proto_errors), 64'd2);
    check("t3.bursts", 64'(burst_count), 64'd1);
    burst(BASE + 64'd256, 0, 3'd5, 2'd1, 4'd6, -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("t3.perr2", 64'(proto_errors), 64'd3);

    // Backpressured response with AWVALID waiting.
    do_reset();
    burst(BASE, 3, 3'd6, 2'd1, 4'd9, -1, -1, -1, 1'b0, 10, 1'b0, 1'b1, -1);

    // Address skip is flagged and does not resync the expectation.
    do_reset();
    burst(BASE, 3, 3'd6, 2'd1, 4'd0, -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    burst(BASE + 64'h400, 3, 3'd6, 2'd1, 4'd1, -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    burst(BASE + 64'h200, 3, 3'd6, 2'd1, 4'd2, -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("t5.aerr", 64'(addr_errors), 64'd1);

    // Single-beat stream across the pattern wrap, clear, restart.
    do_reset();
    for (int i = 0; i < 80; i++)
      burst(BASE + 64'(i * 64), 0, 3'd6, 2'd1, 4'(i), -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("t6.derr", 64'(data_errors), 64'd0);
    check("t6.beats", 64'(beat_count), 64'd80);
    pulse_clear();
    check("t6.clr_beats", 64'(beat_count), 64'd0);
    for (int i = 0; i < 20; i++)
      burst(BASE + 64'(i * 64), 0, 3'd6, 2'd1, 4'(i), -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, -1);
    check("t6.beats2", 64'(beat_count), 64'd20);
    check("t6.error", 64'(error), 64'd0);
    // Clear lands on a beat handshake in the middle of a burst.
    burst(m_addr, 7, 3'd6, 2'd1, 4'd3, -1, -1, -1, 1'b0, 0, 1'b0, 1'b0, 3);

    // Randomized traffic with occasional faults.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      int unsigned l;
      a = m_addr;
      if ($urandom_range(0, 9) == 0) a = a + 64'h40 * 64'($urandom_range(1, 4));
      l = $urandom_range(0, 7);
      burst(a, l,
            ($urandom_range(0, 9) == 0) ? 3'd5 : 3'd6,
            ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd1,
            4'($urandom),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, l)) : -1,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, l)) : -1,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, l)) : -1,
            ($urandom_range(0, 9) == 0),
            $urandom_range(0, 3), 1'b1, 1'b0,
            ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, l)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
